// File: rtl/l1_dm_instr_cache.sv
// Direct-mapped, one-word-per-line L1 instruction cache with a single
// outstanding L2 refill, refill timeout and hit/miss counters.
module l1_dm_instr_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 256,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    output logic                  stall_o,
    output logic                  l2_req_o,
    output logic [ADDR_WIDTH-1:0] l2_addr_o,
    input  logic [DATA_WIDTH-1:0] l2_instr_i,
    input  logic                  l2_hit_i,
    output logic [15:0]           hit_cnt_o,
    output logic [15:0]           miss_cnt_o,
    output logic                  refill_err_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_INSTR = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [DATA_WIDTH-1:0] refill_data;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [15:0]           hit_cnt;
    logic [15:0]           miss_cnt;
    logic                  err_q;

    logic [IDX_W-1:0] pc_idx, miss_idx;
    logic [TAG_W-1:0] pc_tag, miss_tag;
    logic             lookup_hit;
    logic             do_hit, do_miss, line_we, tmo_inc, tmo_abort;

    assign pc_idx     = pc_i[IDX_W+1:2];
    assign pc_tag     = pc_i[ADDR_WIDTH-1:IDX_W+2];
    assign miss_idx   = miss_addr[IDX_W+1:2];
    assign miss_tag   = miss_addr[ADDR_WIDTH-1:IDX_W+2];
    assign lookup_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

    assign hit_cnt_o    = hit_cnt;
    assign miss_cnt_o   = miss_cnt;
    assign refill_err_o = err_q;

    always_comb begin
        state_nxt     = state;
        instr_o       = IDLE_INSTR;
        instr_addr_o  = '0;
        instr_valid_o = 1'b0;
        stall_o       = 1'b0;
        l2_req_o      = 1'b0;
        l2_addr_o     = '0;
        do_hit        = 1'b0;
        do_miss       = 1'b0;
        line_we       = 1'b0;
        tmo_inc       = 1'b0;
        tmo_abort     = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req_i) begin
                    if (lookup_hit) begin
                        instr_o       = data_mem[pc_idx];
                        instr_addr_o  = pc_i;
                        instr_valid_o = 1'b1;
                        do_hit        = 1'b1;
                    end else begin
                        stall_o   = 1'b1;
                        do_miss   = 1'b1;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                l2_req_o  = 1'b1;
                l2_addr_o = miss_addr;
                stall_o   = 1'b1;
                // A flush abandons the refill even when L2 answers in the same cycle.
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (l2_hit_i) begin
                    line_we   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    tmo_abort = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            DONE: begin
                instr_o       = refill_data;
                instr_addr_o  = miss_addr;
                instr_valid_o = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            tmo_cnt  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_i) begin
                valid_q <= '0;
            end else if (line_we) begin
                valid_q[miss_idx] <= 1'b1;
            end
            if (do_miss) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (do_hit) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (do_miss) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (tmo_abort) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag/data storage and refill bookkeeping carry no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (do_miss) begin
            miss_addr <= pc_i;
        end
        if (line_we) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= l2_instr_i;
            refill_data        <= l2_instr_i;
        end
    end

endmodule

// File: tb/tb_l1_dm_instr_cache.sv
// Scoreboard bench for l1_dm_instr_cache: a reference line model predicts
// hit/miss and delivered words; a negedge monitor pops expected deliveries.
module tb_l1_dm_instr_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        stall_o;
    logic        l2_req_o;
    logic [31:0] l2_addr_o;
    logic [31:0] l2_instr_i;
    logic        l2_hit_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;
    logic        refill_err_o;

    l1_dm_instr_cache dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req_i  (fetch_req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .instr_valid_o(instr_valid_o),
        .stall_o      (stall_o),
        .l2_req_o     (l2_req_o),
        .l2_addr_o    (l2_addr_o),
        .l2_instr_i   (l2_instr_i),
        .l2_hit_i     (l2_hit_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
        .refill_err_o (refill_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // reference model of the line array
    bit          mvalid [256];
    logic [21:0] mtag   [256];
    logic [31:0] mdata  [256];
    int          exp_hits;
    int          exp_misses;

    // observations of the most recent do_fetch
    logic        obs_got;
    logic        obs_idle_after;
    logic [31:0] obs_l2addr;
    int          obs_lat;
    int          obs_stalls;
    int          obs_refills;

    always @(negedge clk) begin
        if (!rst && instr_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got instr=%h addr=%h, required no delivery", instr_o, instr_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr_o !== mon_e.instr || instr_addr_o !== mon_e.addr) begin
                    errors++;
                    $display("FAIL delivery: got instr=%h addr=%h, required instr=%h addr=%h",
                             instr_o, instr_addr_o, mon_e.instr, mon_e.addr);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a[9:2]] && (mtag[a[9:2]] == a[31:10]);
    endfunction

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fetch_req_i = 1'b0;
        flush_i = 1'b0;
        l2_hit_i = 1'b0;
        l2_instr_i = '0;
        pc_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // Presents one fetch (called just after a posedge) and plays the L2 side.
    task automatic do_fetch(input logic [31:0] a, input logic l2_ok, input logic [31:0] d,
                            input int hit_after, input logic flush_at_refill);
        int  refills = 0;
        bit  done = 0;
        obs_got = 1'b0;
        obs_idle_after = 1'b0;
        obs_l2addr = '0;
        obs_lat = 0;
        obs_stalls = 0;
        fetch_req_i = 1'b1;
        pc_i = a;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                obs_got = 1'b1;
                obs_lat = cyc;
            end
            if (stall_o) obs_stalls++;
            l2_hit_i = 1'b0;
            flush_i = 1'b0;
            if (l2_req_o) begin
                refills++;
                if (refills == 1) obs_l2addr = l2_addr_o;
                if (flush_at_refill) begin
                    flush_i = 1'b1;
                    l2_hit_i = 1'b1;
                    l2_instr_i = d;
                end else if (l2_ok && refills == hit_after) begin
                    l2_hit_i = 1'b1;
                    l2_instr_i = d;
                end
            end else if (refills > 0 && !instr_valid_o) begin
                obs_idle_after = !stall_o;
                done = 1;
            end
            @(posedge clk);
            #1;
            fetch_req_i = 1'b0;
            l2_hit_i = 1'b0;
            flush_i = 1'b0;
            if (obs_got || done) break;
        end
        obs_refills = refills;
    endtask

    // Successful access: predicts outcome from the model and queues the delivery.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input int n);
        bit   h = model_hit(a);
        exp_t e;
        e.instr = h ? mdata[a[9:2]] : d;
        e.addr = a;
        exp_q.push_back(e);
        do_fetch(a, 1'b1, d, n, 1'b0);
        if (h) begin
            exp_hits++;
        end else begin
            exp_misses++;
            mvalid[a[9:2]] = 1'b1;
            mtag[a[9:2]] = a[31:10];
            mdata[a[9:2]] = d;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", instr_valid_o); end
        checks++; if (instr_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_instr: got %h, required deadbeef", instr_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL rst_iaddr: got %h, required 0", instr_addr_o); end
        checks++; if (stall_o !== 1'b0 || l2_req_o !== 1'b0) begin errors++; $display("FAIL rst_stall_req: got %b/%b, required 0/0", stall_o, l2_req_o); end
        checks++; if (l2_addr_o !== 32'h0) begin errors++; $display("FAIL rst_l2addr: got %h, required 0", l2_addr_o); end
        checks++; if (hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_counters: got %h/%h, required 0/0", hit_cnt_o, miss_cnt_o); end
        checks++; if (refill_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", refill_err_o); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        access(32'h0000_0100, 32'h0051_0513, 1);
        checks++; if (obs_got !== 1'b1 || obs_lat != 3) begin errors++; $display("FAIL cold_latency: got valid=%b lat=%0d, required valid=1 lat=3", obs_got, obs_lat); end
        checks++; if (obs_stalls != 2) begin errors++; $display("FAIL cold_stalls: got %0d, required 2", obs_stalls); end
        checks++; if (obs_l2addr !== 32'h0000_0100) begin errors++; $display("FAIL cold_l2addr: got %h, required 00000100", obs_l2addr); end
        checks++; if (miss_cnt_o !== 16'd1 || hit_cnt_o !== 16'd0) begin errors++; $display("FAIL cold_counters: got miss=%0d hit=%0d, required miss=1 hit=0", miss_cnt_o, hit_cnt_o); end
    endtask

    task automatic test_warm_hit();
        access(32'h0000_0100, 32'h0, 1);
        checks++; if (obs_lat != 1 || obs_stalls != 0) begin errors++; $display("FAIL warm_latency: got lat=%0d stalls=%0d, required lat=1 stalls=0", obs_lat, obs_stalls); end
        checks++; if (hit_cnt_o !== 16'd1 || miss_cnt_o !== 16'd1) begin errors++; $display("FAIL warm_counters: got hit=%0d miss=%0d, required hit=1 miss=1", hit_cnt_o, miss_cnt_o); end
    endtask

    task automatic test_conflict();
        access(32'h0000_0500, 32'h00A0_0093, 1);
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL conflict_first: got lat=%0d, required 3", obs_lat); end
        access(32'h0000_0100, 32'h0051_0513, 2);
        checks++; if (obs_lat != 4) begin errors++; $display("FAIL conflict_evicted: got lat=%0d, required 4", obs_lat); end
        checks++; if (miss_cnt_o !== 16'd3) begin errors++; $display("FAIL conflict_misses: got %0d, required 3", miss_cnt_o); end
    endtask

    task automatic test_timeout();
        checks++; if (refill_err_o !== 1'b0) begin errors++; $display("FAIL err_before: got %b, required 0", refill_err_o); end
        do_fetch(32'h0000_2000, 1'b0, 32'h0, 1, 1'b0);
        exp_misses++;
        checks++; if (obs_got !== 1'b0) begin errors++; $display("FAIL timeout_delivery: got %b, required 0", obs_got); end
        checks++; if (obs_refills != 15) begin errors++; $display("FAIL timeout_cycles: got %0d, required 15", obs_refills); end
        checks++; if (refill_err_o !== 1'b1 || obs_idle_after !== 1'b1) begin errors++; $display("FAIL timeout_err: got err=%b idle=%b, required 1/1", refill_err_o, obs_idle_after); end
        access(32'h0000_2000, 32'h1234_5678, 2);
        checks++; if (obs_lat != 4) begin errors++; $display("FAIL timeout_line_invalid: got lat=%0d, required 4", obs_lat); end
        checks++; if (refill_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", refill_err_o); end
    endtask

    task automatic test_flush();
        access(32'h0000_0100, 32'h0051_0513, 1);
        checks++; if (obs_lat != 1) begin errors++; $display("FAIL flush_prehit: got lat=%0d, required 1", obs_lat); end
        do_fetch(32'h0000_0300, 1'b1, 32'hCAFE_0001, 1, 1'b1);
        exp_misses++;
        model_clear();
        checks++; if (obs_got !== 1'b0 || obs_refills != 1 || obs_idle_after !== 1'b1) begin
            errors++;
            $display("FAIL flush_abort: got valid=%b refills=%0d idle=%b, required 0/1/1", obs_got, obs_refills, obs_idle_after);
        end
        access(32'h0000_0100, 32'h0051_0513, 1);
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL flush_refetch: got lat=%0d, required 3", obs_lat); end
        access(32'h0000_0300, 32'hCAFE_0002, 1);
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL flush_nowrite: got lat=%0d, required 3", obs_lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int          waits [4];
        exp_t        e;
        addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_1004;
        addrs[2] = 32'h0000_1008; addrs[3] = 32'h0000_100C;
        waits[0] = 1; waits[1] = 2; waits[2] = 3; waits[3] = 5;
        for (int i = 0; i < 4; i++) begin
            access(addrs[i], 32'hB000_0000 + 32'(i), waits[i]);
            checks++;
            if (obs_lat != 2 + waits[i]) begin errors++; $display("FAIL b2b_fill_lat[%0d]: got %0d, required %0d", i, obs_lat, 2 + waits[i]); end
        end
        for (int k = 0; k < 8; k++) begin
            fetch_req_i = 1'b1;
            pc_i = addrs[k % 4];
            e.instr = 32'hB000_0000 + 32'(k % 4);
            e.addr = addrs[k % 4];
            exp_q.push_back(e);
            exp_hits++;
            @(negedge clk);
            checks++;
            if (instr_valid_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL b2b_hit[%0d]: got valid=%b stall=%b, required 1/0", k, instr_valid_o, stall_o); end
            @(posedge clk);
            #1;
        end
        fetch_req_i = 1'b0;
        checks++; if (hit_cnt_o !== 16'(exp_hits) || miss_cnt_o !== 16'(exp_misses)) begin
            errors++;
            $display("FAIL b2b_counters: got hit=%0d miss=%0d, required hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o, exp_hits, exp_misses);
        end
    endtask

    task automatic test_counter_wrap();
        exp_t e;
        apply_reset();
        access(32'h0000_0100, 32'h0051_0513, 1);
        e.instr = 32'h0051_0513;
        e.addr = 32'h0000_0100;
        fetch_req_i = 1'b1;
        pc_i = 32'h0000_0100;
        for (int i = 0; i < 65535; i++) begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        fetch_req_i = 1'b0;
        checks++; if (hit_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h, required ffff", hit_cnt_o); end
        access(32'h0000_0100, 32'h0, 1);
        checks++; if (hit_cnt_o !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h, required 0000", hit_cnt_o); end
        checks++; if (miss_cnt_o !== 16'd1) begin errors++; $display("FAIL wrap_misses: got %0d, required 1", miss_cnt_o); end
    endtask

    task automatic test_rst_mid_refill();
        fetch_req_i = 1'b1;
        pc_i = 32'h0000_0700;
        @(posedge clk);
        #1 fetch_req_i = 1'b0;
        @(negedge clk);
        checks++; if (l2_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_inrefill: got l2_req=%b, required 1", l2_req_o); end
        l2_hit_i = 1'b1;
        l2_instr_i = 32'h7777_7777;
        rst = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0 || l2_req_o !== 1'b0 || l2_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_l2: got stall=%b req=%b addr=%h, required 0/0/0", stall_o, l2_req_o, l2_addr_o);
        end
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'hDEADBEEF || miss_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_out: got valid=%b instr=%h miss=%0d, required 0/deadbeef/0", instr_valid_o, instr_o, miss_cnt_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        l2_hit_i = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        access(32'h0000_0700, 32'h0070_0001, 1);
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL rstmid_line_invalid: got lat=%0d, required 3", obs_lat); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_warm_hit();
        test_conflict();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_counter_wrap();
        test_rst_mid_refill();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_dm_instr_cache.md
L1_DM_INSTR_CACHE -- requirements
Module: l1_dm_instr_cache

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 32, address width
  DATA_WIDTH, 32, instruction width
  NUM_LINES, 256, direct-mapped lines of one word each
  TIMEOUT, 15, maximum REFILL cycles before abort
REQ-002 One clock; reset is asynchronous and active-high. Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  fetch_req_i  in  1  core requests instruction at pc_i
  pc_i  in  ADDR_WIDTH  fetch address (byte, word-aligned)
  flush_i  in  1  invalidate all lines
  instr_o  out  DATA_WIDTH  delivered instruction
  instr_addr_o  out  ADDR_WIDTH  address of delivered instruction
  instr_valid_o  out  1  instr_o valid this cycle
  stall_o  out  1  core must hold pc_i
  l2_req_o  out  1  L2 lookup active
  l2_addr_o  out  ADDR_WIDTH  L2 lookup address
  l2_instr_i  in  DATA_WIDTH  L2 read data
  l2_hit_i  in  1  L2 hit; l2_instr_i valid
  hit_cnt_o  out  16  L1 hit count
  miss_cnt_o  out  16  L1 miss count
  refill_err_o  out  1  sticky refill-timeout flag

Function
REQ-003 Index SHALL be pc[log2(NUM_LINES)+1:2]; tag SHALL be pc[ADDR_WIDTH-1:log2(NUM_LINES)+2]; pc[1:0] SHALL be ignored.
REQ-004 Per-line storage SHALL be valid bit (flops), tag, data; only valid bits are reset.
REQ-005 FSM states SHALL be IDLE, REFILL, DONE.
REQ-006 IDLE, fetch_req_i=1, line valid and tag match: same cycle instr_o=line data, instr_addr_o=pc_i, instr_valid_o=1, stall_o=0, hit_cnt_o+1 at edge; stay IDLE.
REQ-007 IDLE, fetch_req_i=1, miss: stall_o=1, instr_valid_o=0; at edge latch pc_i into miss_addr, clear timeout counter, miss_cnt_o+1, go REFILL.
REQ-008 IDLE, fetch_req_i=0: all outputs idle, no counter change.
REQ-009 REFILL: l2_req_o=1, l2_addr_o=miss_addr, stall_o=1; pc_i and fetch_req_i ignored.
REQ-010 REFILL with l2_hit_i=1: at edge write tag/data/valid of miss_addr line, capture l2_instr_i, go DONE.
REQ-011 REFILL with l2_hit_i=0: timeout counter +1; when counter reaches TIMEOUT without hit, at that edge set refill_err_o, no line write, go IDLE.
REQ-012 DONE: instr_o=captured data, instr_addr_o=miss_addr, instr_valid_o=1, stall_o=0, l2_req_o=0; go IDLE next edge.
REQ-013 Miss latency SHALL be 1 (detect) + N (REFILL cycles, N>=1) + 1 (DONE) cycles to instr_valid_o.
REQ-014 flush_i SHALL clear all valid bits at the edge; in REFILL it SHALL abort to IDLE without line write; in DONE the delivery SHALL complete; flush_i wins over a simultaneous refill write.
REQ-015 When l2_req_o=0, l2_addr_o SHALL be 0; when instr_valid_o=0, instr_o SHALL be 32'hDEADBEEF and instr_addr_o 0.
REQ-016 hit_cnt_o and miss_cnt_o SHALL wrap 16'hFFFF -> 0; refill_err_o cleared only by rst.

Reset
REQ-017 rst=1 SHALL asynchronously force state IDLE, all valid bits 0, counters 0, refill_err_o 0, timeout counter 0, all outputs to REQ-015 idle values, stall_o 0, l2_req_o 0.
REQ-018 rst asserted mid-REFILL SHALL abandon the refill with no line write.

Verification
REQ-019 Cold miss: rst, then fetch pc=0x0000_0100, l2_hit_i=1 on 1st REFILL cycle with 0x0051_0513 -> stall 2 cycles, instr_valid_o in cycle 3, instr_o=0x0051_0513, miss_cnt_o=1.
REQ-020 Warm hit: refetch 0x0000_0100 -> same-cycle instr_valid_o=1, instr_o=0x0051_0513, hit_cnt_o=1.
REQ-021 Conflict: fetch 0x0000_0500 (same index, other tag) after REQ-019 -> miss, refill replaces line; refetch 0x0000_0100 -> miss again.
REQ-022 Timeout: l2_hit_i held 0 -> after 15 REFILL cycles refill_err_o=1, state IDLE, line still invalid, no instr_valid_o.
REQ-023 Flush: flush_i in REFILL cycle with l2_hit_i=1 -> no write, IDLE next cycle; refetch of any prior-hit address misses.
REQ-024 Counter wrap and reset: 65536 hits -> hit_cnt_o=0; rst mid-REFILL -> all outputs idle immediately, line invalid.
